// File: rtl/jt7759_pkg.sv
// Shared jt7759 definitions: default ROM widths and the one-hot state
// encoding of the ROM arbiter.
package jt7759_pkg;

    localparam int JT7759_AW = 17;
    localparam int JT7759_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_GAP  = 3'b100
    } arb_state_t;

endpackage

// File: rtl/jt7759_romarb_lat.sv
// One-entry result latch of a jt7759 channel: remembers the last byte fetched
// for that channel and answers repeated reads of the same address locally.
module jt7759_romarb_lat #(
    parameter int AW = 17,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          inv,
    output logic          hit,
    output logic [DW-1:0] data,
    output logic          ok
);

    logic          vld_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] dat_r;
    logic [DW-1:0] data_r;
    logic          ok_r;
    logic          fill_hit_s;

    assign hit        = cs & vld_r & (addr_r == addr);
    // A fill matching the live address answers in the same edge it is stored
    assign fill_hit_s = wr & cs & (wr_addr == addr);
    assign data       = data_r;
    assign ok         = ok_r;

    // Latch contents: written by a completed fetch, invalidated by a timeout
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_r  <= 1'b0;
            addr_r <= '0;
            dat_r  <= '0;
        end else if (wr) begin
            vld_r  <= 1'b1;
            addr_r <= wr_addr;
            dat_r  <= wr_data;
        end else if (inv) begin
            vld_r  <= 1'b0;
        end
    end

    // Registered ok/data presented to the channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ok_r   <= 1'b0;
            data_r <= '0;
        end else begin
            ok_r <= hit | fill_hit_s;
            if (fill_hit_s) begin
                data_r <= wr_data;
            end else if (hit) begin
                data_r <= dat_r;
            end
        end
    end

endmodule

// File: rtl/jt7759_romarb.sv
// Shares one external sample ROM port between two jt7759 channels with
// round-robin arbitration, per-channel result latches and a wait timeout.
module jt7759_romarb
    import jt7759_pkg::*;
#(
    parameter int AW   = JT7759_AW,
    parameter int DW   = JT7759_DW,
    parameter int TOUT = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ch0_cs,
    input  logic [AW-1:0] ch0_addr,
    output logic [DW-1:0] ch0_data,
    output logic          ch0_ok,
    input  logic          ch1_cs,
    input  logic [AW-1:0] ch1_addr,
    output logic [DW-1:0] ch1_data,
    output logic          ch1_ok,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok,
    output logic          owner,
    output logic          tout_err
);

    localparam int             CW     = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
    localparam logic [CW-1:0]  TOUT_C = CW'(TOUT);

    arb_state_t    state_r, state_nxt_s;
    logic          rom_cs_r, rom_cs_nxt_s;
    logic [AW-1:0] rom_addr_r, rom_addr_nxt_s;
    logic          owner_r, owner_nxt_s;
    logic          tout_r, tout_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic          hit0_s, hit1_s, pend0_s, pend1_s, grant_s, to_s;
    logic          wr0_s, wr1_s, inv0_s, inv1_s;

    assign pend0_s   = ch0_cs & ~hit0_s & ~((state_r != ST_IDLE) & ~owner_r);
    assign pend1_s   = ch1_cs & ~hit1_s & ~((state_r != ST_IDLE) &  owner_r);
    assign grant_s   = (pend0_s & pend1_s) ? ~owner_r : pend1_s;
    assign cnt_inc_s = cnt_r + CW'(1);
    assign to_s      = (TOUT != 0) && (cnt_inc_s == TOUT_C);

    assign rom_cs   = rom_cs_r;
    assign rom_addr = rom_addr_r;
    assign owner    = owner_r;
    assign tout_err = tout_r;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pend0_s | pend1_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (rom_ok | to_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath next values and latch write strobes
    always_comb begin
        rom_cs_nxt_s   = rom_cs_r;
        rom_addr_nxt_s = rom_addr_r;
        owner_nxt_s    = owner_r;
        tout_nxt_s     = tout_r;
        cnt_nxt_s      = cnt_r;
        wr0_s          = 1'b0;
        wr1_s          = 1'b0;
        inv0_s         = 1'b0;
        inv1_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pend0_s | pend1_s) begin
                    owner_nxt_s    = grant_s;
                    rom_addr_nxt_s = grant_s ? ch1_addr : ch0_addr;
                    rom_cs_nxt_s   = 1'b1;
                    cnt_nxt_s      = '0;
                end else begin
                    rom_cs_nxt_s   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (rom_ok) begin
                    wr0_s        = ~owner_r;
                    wr1_s        = owner_r;
                    rom_cs_nxt_s = 1'b0;
                end else if (to_s) begin
                    inv0_s       = ~owner_r;
                    inv1_s       = owner_r;
                    tout_nxt_s   = 1'b1;
                    rom_cs_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s    = cnt_inc_s;
                end
            end
            ST_GAP:  rom_cs_nxt_s = 1'b0;
            default: rom_cs_nxt_s = 1'b0;
        endcase
    end

    // Registered ROM-side outputs, owner, timeout flag and wait counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rom_cs_r   <= 1'b0;
            rom_addr_r <= '0;
            owner_r    <= 1'b1;
            tout_r     <= 1'b0;
            cnt_r      <= '0;
        end else begin
            rom_cs_r   <= rom_cs_nxt_s;
            rom_addr_r <= rom_addr_nxt_s;
            owner_r    <= owner_nxt_s;
            tout_r     <= tout_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    jt7759_romarb_lat #(.AW(AW), .DW(DW)) u_lat0 (
        .clk     (clk),
        .rstn    (rstn),
        .cs      (ch0_cs),
        .addr    (ch0_addr),
        .wr      (wr0_s),
        .wr_addr (rom_addr_r),
        .wr_data (rom_data),
        .inv     (inv0_s),
        .hit     (hit0_s),
        .data    (ch0_data),
        .ok      (ch0_ok)
    );

    jt7759_romarb_lat #(.AW(AW), .DW(DW)) u_lat1 (
        .clk     (clk),
        .rstn    (rstn),
        .cs      (ch1_cs),
        .addr    (ch1_addr),
        .wr      (wr1_s),
        .wr_addr (rom_addr_r),
        .wr_data (rom_data),
        .inv     (inv1_s),
        .hit     (hit1_s),
        .data    (ch1_data),
        .ok      (ch1_ok)
    );

endmodule

// File: tb/tb_jt7759_romarb.sv
// Directed bench for jt7759_romarb with a ROM model answering on the fifth
// cycle of rom_cs; the timeout is shortened to 8 cycles.
module tb_jt7759_romarb;

    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk;
    logic          rstn;
    logic          ch0_cs, ch1_cs;
    logic [AW-1:0] ch0_addr, ch1_addr;
    logic [DW-1:0] ch0_data, ch1_data;
    logic          ch0_ok, ch1_ok;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rom_ok;
    logic          owner;
    logic          tout_err;

    logic          rom_en;
    int            rcnt;
    int            n_cmp;
    int            n_mis;

    jt7759_romarb #(.AW(AW), .DW(DW), .TOUT(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ch0_cs   (ch0_cs),
        .ch0_addr (ch0_addr),
        .ch0_data (ch0_data),
        .ch0_ok   (ch0_ok),
        .ch1_cs   (ch1_cs),
        .ch1_addr (ch1_addr),
        .ch1_data (ch1_data),
        .ch1_ok   (ch1_ok),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .owner    (owner),
        .tout_err (tout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ROM model: updates mid-cycle, answers on the 5th cycle of a rom_cs burst
    always @(negedge clk) begin
        if (rom_cs) rcnt = rcnt + 1;
        else        rcnt = 0;
        rom_ok   = rom_en && (rcnt == 5);
        rom_data = rom_ok ? rom_byte(rom_addr) : 8'h00;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; rcnt = 0;
        rom_ok = 1'b0; rom_data = 8'h00; rom_en = 1'b1;
        rstn = 1'b0;
        ch0_cs = 1'b0; ch0_addr = '0;
        ch1_cs = 1'b0; ch1_addr = '0;
        tick(3);
        chk("rst_rom_cs",   32'(rom_cs),   32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_owner",    32'(owner),    32'h1);
        chk("rst_tout",     32'(tout_err), 32'h0);
        chk("rst_ok",       32'({ch0_ok, ch1_ok}), 32'h0);
        chk("rst_data",     32'({ch0_data, ch1_data}), 32'h0);
        rstn = 1'b1;
        tick(1);

        // Single miss on ch0
        ch0_cs = 1'b1; ch0_addr = 17'h00123;
        tick(1);
        chk("miss_rom_cs",   32'(rom_cs),   32'h1);
        chk("miss_rom_addr", 32'(rom_addr), 32'h00123);
        chk("miss_owner",    32'(owner),    32'h0);
        tick(4);
        chk("miss_wait_cs",  32'(rom_cs),   32'h1);
        chk("miss_wait_ok",  32'(ch0_ok),   32'h0);
        tick(1);
        chk("miss_ok",       32'(ch0_ok),   32'h1);
        chk("miss_data",     32'(ch0_data), 32'(rom_byte(17'h00123)));
        chk("miss_gap_cs",   32'(rom_cs),   32'h0);
        tick(2);
        chk("hold_ok",       32'(ch0_ok),   32'h1);
        chk("hold_no_cs",    32'(rom_cs),   32'h0);

        // Re-request of the latched address after one idle cycle
        ch0_cs = 1'b0;
        tick(1);
        chk("drop_ok",       32'(ch0_ok),   32'h0);
        ch0_cs = 1'b1;
        tick(1);
        chk("rehit_ok",      32'(ch0_ok),   32'h1);
        chk("rehit_data",    32'(ch0_data), 32'(rom_byte(17'h00123)));
        chk("rehit_cs",      32'(rom_cs),   32'h0);
        tick(1);
        chk("rehit_cs2",     32'(rom_cs),   32'h0);
        ch0_cs = 1'b0;

        // Simultaneous requests after reset: ch0 first, then ch1
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        tick(1);
        ch0_cs = 1'b1; ch0_addr = 17'h00010;
        ch1_cs = 1'b1; ch1_addr = 17'h00020;
        tick(1);
        chk("rr1_addr",  32'(rom_addr), 32'h00010);
        chk("rr1_owner", 32'(owner),    32'h0);
        tick(5);
        chk("rr1_ok0",   32'(ch0_ok),   32'h1);
        chk("rr1_data0", 32'(ch0_data), 32'(rom_byte(17'h00010)));
        chk("rr1_ok1",   32'(ch1_ok),   32'h0);
        tick(2);
        chk("rr2_cs",    32'(rom_cs),   32'h1);
        chk("rr2_addr",  32'(rom_addr), 32'h00020);
        chk("rr2_owner", 32'(owner),    32'h1);
        tick(5);
        chk("rr2_ok1",   32'(ch1_ok),   32'h1);
        chk("rr2_data1", 32'(ch1_data), 32'(rom_byte(17'h00020)));
        chk("rr2_keep0", 32'({ch0_ok, ch0_data}), 32'({1'b1, rom_byte(17'h00010)}));
        ch0_addr = 17'h00030;
        ch1_addr = 17'h00050;
        tick(2);
        chk("rr3_addr",  32'(rom_addr), 32'h00030);
        chk("rr3_owner", 32'(owner),    32'h0);
        tick(5);
        chk("rr3_ok0",   32'(ch0_ok),   32'h1);
        tick(2);
        chk("rr4_addr",  32'(rom_addr), 32'h00050);
        chk("rr4_owner", 32'(owner),    32'h1);
        tick(5);
        chk("rr4_data1", 32'({ch1_ok, ch1_data}), 32'({1'b1, rom_byte(17'h00050)}));
        ch0_cs = 1'b0; ch1_cs = 1'b0;
        tick(1);

        // ch1 changes address while its fetch is in flight
        ch1_cs = 1'b1; ch1_addr = 17'h00040;
        tick(1);
        chk("chg_addr",  32'(rom_addr), 32'h00040);
        tick(1);
        ch1_addr = 17'h00041;
        tick(4);
        chk("chg_done_cs", 32'(rom_cs),  32'h0);
        chk("chg_no_ok",   32'(ch1_ok),  32'h0);
        tick(2);
        chk("chg_reissue", 32'({rom_cs, rom_addr}), 32'({1'b1, 17'h00041}));
        chk("chg_wait_ok", 32'(ch1_ok),  32'h0);
        tick(5);
        chk("chg_ok",    32'({ch1_ok, ch1_data}), 32'({1'b1, rom_byte(17'h00041)}));
        ch1_cs = 1'b0;
        tick(2);

        // Timeout: ROM silent for 8 WAIT cycles
        rom_en = 1'b0;
        ch0_cs = 1'b1; ch0_addr = 17'h00077;
        tick(8);
        chk("to_cs_held", 32'(rom_cs),   32'h1);
        chk("to_err_0",   32'(tout_err), 32'h0);
        tick(1);
        chk("to_cs_drop", 32'(rom_cs),   32'h0);
        chk("to_err_1",   32'(tout_err), 32'h1);
        chk("to_no_ok",   32'(ch0_ok),   32'h0);
        tick(2);
        chk("to_reissue", 32'({rom_cs, rom_addr}), 32'({1'b1, 17'h00077}));
        rom_en = 1'b1;
        tick(5);
        chk("to_ok",      32'({ch0_ok, ch0_data}), 32'({1'b1, rom_byte(17'h00077)}));
        chk("to_sticky",  32'(tout_err), 32'h1);

        // Asynchronous reset in the middle of a ch1 fetch
        ch1_cs = 1'b1; ch1_addr = 17'h00099;
        tick(2);
        chk("ar_wait_cs", 32'({rom_cs, owner}), 32'h3);
        tick(1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_cs_async", 32'(rom_cs),   32'h0);
        chk("ar_tout_clr", 32'(tout_err), 32'h0);
        chk("ar_ok_clr",   32'(ch0_ok),   32'h0);
        ch1_cs = 1'b0;
        #2;
        rstn = 1'b1;
        tick(1);
        chk("ar_refetch", 32'({rom_cs, rom_addr}), 32'({1'b1, 17'h00077}));
        chk("ar_no_hit",  32'(ch0_ok),   32'h0);
        tick(5);
        chk("ar_ok",      32'({ch0_ok, ch0_data}), 32'({1'b1, rom_byte(17'h00077)}));
        ch0_cs = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
